// File: rtl/if_id_queue_pkg.sv
// Shared CPU definitions for the IF/ID queue: default widths, the NOP encoding
// and the {pc, inst} entry record that the id_ex stage reuses.
package if_id_queue_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int INST_W_DEF = 16;

  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = 16'h0800;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } entry_t;

endpackage

// File: rtl/if_id_queue_ring_ptr.sv
// Wrap-around pointer for the IF/ID queue; clears on reset or clr, else
// advances by one on inc, wrapping naturally at 2**W.
module if_id_queue_ring_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID stage as a DEPTH-entry FIFO of {pc, inst} with flush and NOP-on-empty.
// Optional macro IF_ID_QUEUE_PASS_EN lets a full queue accept a push during a pop.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                 PC_W     = PC_W_DEF,
  parameter int                 INST_W   = INST_W_DEF,
  parameter int                 DEPTH    = 4,
  parameter logic [INST_W-1:0]  NOP_INST = NOP_INST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [INST_W-1:0]          inst_in,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [PC_W-1:0]            pc_out,
  output logic [INST_W-1:0]          inst_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // Upstream: push = in_valid && in_ready. Downstream: pop = out_valid && !hold.
  assign out_valid = (count != '0);
  assign pop       = out_valid && !hold;
`ifdef IF_ID_QUEUE_PASS_EN
  assign in_ready  = (count != CW'(DEPTH)) || pop;
`else
  assign in_ready  = (count != CW'(DEPTH));
`endif
  assign push      = in_valid && in_ready;

  // Head is read from the flops only, so no input reaches pc_out/inst_out.
  assign pc_out   = out_valid ? pc_mem[rd_ptr]   : '0;
  assign inst_out = out_valid ? inst_mem[rd_ptr] : NOP_INST;

  if_id_queue_ring_ptr #(.W(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  if_id_queue_ring_ptr #(.W(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage is don't-care after reset/flush, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc_in;
      inst_mem[wr_ptr] <= inst_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pc_in;
  logic [15:0] inst_in;
  logic        hold;
  logic        flush;
  logic        out_valid;
  logic [15:0] pc_out;
  logic [15:0] inst_out;
  logic [2:0]  count;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  logic        m_pushed;

`ifdef IF_ID_QUEUE_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .hold      (hold),
    .flush     (flush),
    .out_valid (out_valid),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .count     (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    logic pop_ok;
    pop_ok = (exp_q.size() != 0) && !hold;
    return (exp_q.size() != DEPTH) || (PASS && pop_ok);
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = (exp_q.size() != 0);
    check("count",     {29'd0, count},     32'(exp_q.size()));
    check("out_valid", {31'd0, out_valid}, {31'd0, ev});
    check("pc_out",    {16'd0, pc_out},    ev ? {16'd0, exp_q[0][31:16]} : 32'd0);
    check("inst_out",  {16'd0, inst_out},  ev ? {16'd0, exp_q[0][15:0]} : {16'd0, NOP});
    check("in_ready",  {31'd0, in_ready},  {31'd0, model_ready()});
  endtask

  // Model: a queue of {pc, inst}; reset/flush empty it and drop any push.
  task automatic model_update();
    logic do_push;
    logic do_pop;
    m_pushed = 1'b0;
    if (!rst || flush) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && model_ready();
      do_pop  = (exp_q.size() != 0) && !hold;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({pc_in, inst_in});
        m_pushed = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [15:0] pc,
                      input logic [15:0] inst, input logic h, input logic f);
    @(negedge clk);
    rst = r; in_valid = iv; pc_in = pc; inst_in = inst; hold = h; flush = f;
    #1;
    check_outputs();
    model_update();
  endtask

  // Presents pc/inst until accepted, within a cycle budget.
  task automatic push_until(input logic [15:0] pc, input logic [15:0] inst,
                            input logic h, input int budget);
    int n;
    n = 0;
    m_pushed = 1'b0;
    while (!m_pushed && n < budget) begin
      step(1'b1, 1'b1, pc, inst, h, 1'b0);
      n++;
    end
    check("push_timeout", {31'd0, m_pushed}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; in_valid = 1'b1; pc_in = 16'h1111; inst_in = 16'h2222;
    hold = 1'b0; flush = 1'b0;
    @(posedge clk);

    // reset held with in_valid high
    step(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);

    // single flow
    step(1'b1, 1'b1, 16'h0010, 16'h6A05, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // fill under stall, fifth push refused
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b1, 16'(i), 16'(32'h7000 + i), 1'b1, 1'b0);
    push_until(16'h0005, 16'h7005, 1'b0, 8);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // wrap-around stream with hold toggling every 3 cycles
    begin
      int cyc;
      cyc = 0;
      for (int i = 0; i < 10; i++) begin
        m_pushed = 1'b0;
        while (!m_pushed && cyc < 200) begin
          step(1'b1, 1'b1, 16'(32'h0100 + i), 16'($urandom), ((cyc / 3) % 2) == 1, 1'b0);
          cyc++;
        end
      end
      check("wrap_timeout", {31'd0, m_pushed}, 32'd1);
      for (int i = 0; i < 8; i++)
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    end

    // flush collides with a push at count=3
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'(32'h0030 + i), 16'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h0050, 16'h4321, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // full pass-through behaviour
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 16'(32'h0060 + i), 16'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h0077, 16'h0077, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("pass_count", {29'd0, count}, PASS ? 32'd4 : 32'd3);
    // reset while full behaves like flush
    step(1'b0, 1'b1, 16'h0099, 16'h0099, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
           16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID stage for the 16-bit pipeline. It replaces the single-entry fetch/decode latch with a DEPTH-entry FIFO of {pc, inst} pairs, which decouples fetch from decode stalls. It adds valid/ready handshaking, branch flush and NOP injection when empty. It sits between the fetch unit (PC + instruction memory) and the decode stage.

## Interface
- PC_W, 16, width of pc fields
- INST_W, 16, width of instruction fields
- DEPTH, 4, entry count; power of two, ≥2
- NOP_INST, 16'h0800, instruction presented when the queue is empty
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  fetch presents pc_in/inst_in this cycle
- in_ready  output  1  queue accepts a push this cycle
- pc_in  input  PC_W  fetched PC
- inst_in  input  INST_W  fetched instruction
- hold  input  1  decode stall; blocks pop
- flush  input  1  branch/jump redirect; discards all entries
- out_valid  output  1  head entry is real
- pc_out  output  PC_W  head PC; 0 when empty
- inst_out  output  INST_W  head instruction; NOP_INST when empty
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry register array plus wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH; natural overflow applies because DEPTH is a power of two.
  - count is a separate register.
- push = in_valid && in_ready.
- pop = out_valid && !hold.
- in_ready = (count != DEPTH), subject to the Configuration section.
- out_valid = (count != 0).
- Head outputs are driven combinationally from the flops, never from inputs:
  - pc_out = out_valid ? mem[rd_ptr].pc : 0.
  - inst_out = out_valid ? mem[rd_ptr].inst : NOP_INST.
- Update priority, highest first: !rst, flush, push/pop.
  - !rst or flush: wr_ptr=0, rd_ptr=0, count=0. Any same-cycle push is dropped. Storage contents are don't-care.
  - Push only: write mem[wr_ptr], wr_ptr+1, count+1.
  - Pop only: rd_ptr+1, count−1.
  - Push and pop together: both pointers advance and count is unchanged. This is legal at any occupancy where push is accepted.
- hold during empty has no effect: no pop is possible, and NOP_INST is presented.
- Reset values: out_valid=0, pc_out=0, inst_out=NOP_INST, count=0, in_ready=1.

## Timing
- Push-to-output latency is 1 cycle. An entry pushed at edge k is visible on pc_out/inst_out after edge k if the queue was empty before k.
- Pop takes effect at the edge. The next entry, or NOP, is visible after that edge.
- in_ready is a function of registered count only (no combinational path from hold/in_valid), unless the Configuration macro is defined.
- Flush asserted at edge k: after edge k, out_valid=0 and inst_out=NOP_INST, and in_ready=1 in the cycle after k. A push in the cycle after flush is accepted normally.
- Reset asserted while the queue is full, mid-operation: identical to flush.
- Full + push + no pop: push is not accepted (in_ready=0). Fetch must hold its pc_in/inst_in until it sees in_ready.

## Configuration
- IF_ID_QUEUE_PASS_EN defined:
  - in_ready = (count != DEPTH) || pop.
  - A full queue accepts a push in the same cycle a pop occurs, which gives full throughput at occupancy DEPTH.
  - This adds a combinational path from hold to in_ready.
- IF_ID_QUEUE_PASS_EN undefined:
  - in_ready = (count != DEPTH).
  - At full, a pop frees the slot and the push lands one cycle later.

## Structure
- Shared CPU package/header holds:
  - NOP_INST (16'h0800).
  - Default PC_W/INST_W.
  - The {pc, inst} entry record typedef, also reused by id_ex.
- One sub-module is natural: ring_ptr, a parametrised wrap-around pointer with inc and clr inputs. It is instantiated twice, for rd and wr.
- Storage and count stay inline.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 → count=0, out_valid=0, pc_out=0, inst_out=16'h0800 throughout; no entry pushed.
- Single flow: push pc=0x0010/inst=0x6A05 with hold=0 → visible one cycle later with out_valid=1; popped next edge; output returns to NOP.
- Fill/stall, DEPTH=4: hold=1, push pcs 0x0001..0x0005 back-to-back →
  - Four accepted; in_ready=0 on the fifth, count=4.
  - Release hold: pcs 0x0001..0x0004 emerge in order, then 0x0005 after it is re-presented.
- Wrap-around: stream 10 entries with hold toggling every 3 cycles → output order matches input order exactly, and count never exceeds 4.
- Flush collision: count=3, assert flush together with in_valid=1 (pc=0x0040) and hold=0 → after the edge, count=0 and inst_out=16'h0800; pc 0x0040 is never output.
- Full pass-through: count=4, hold=0, in_valid=1:
  - With IF_ID_QUEUE_PASS_EN, in_ready=1 and count stays 4.
  - Without it, in_ready=0 and count goes to 3.
